// File: rtl/exc_commit_if.sv
// Exception commit bus: pipeline-side exception request, MTC0 write port,
// fetch-side redirect handshake and the architectural CP0 register outputs.
// The commit unit (exc_commit) uses the slave modport; the pipeline and
// fetch logic around it use the master modport.
interface exc_commit_if #(
  parameter int EXCT_W = 5
);
  logic              exc_flag;
  logic [EXCT_W-1:0] exc_type;
  logic [31:0]       exc_baddr;
  logic [31:0]       pc;
  logic              in_delay;
  logic              m_wr;
  logic [5:0]        ext_int;
  logic              cp0_we;
  logic [4:0]        cp0_waddr;
  logic [31:0]       cp0_wdata;
  logic              redir_ack;
  logic              flush;
  logic              redir_valid;
  logic [31:0]       redir_pc;
  logic              exc_intr;
  logic [31:0]       status;
  logic [31:0]       cause;
  logic [31:0]       epc;
  logic [31:0]       badvaddr;

  modport master (
    output exc_flag, exc_type, exc_baddr, pc, in_delay, m_wr, ext_int,
           cp0_we, cp0_waddr, cp0_wdata, redir_ack,
    input  flush, redir_valid, redir_pc, exc_intr,
           status, cause, epc, badvaddr
  );

  modport slave (
    input  exc_flag, exc_type, exc_baddr, pc, in_delay, m_wr, ext_int,
           cp0_we, cp0_waddr, cp0_wdata, redir_ack,
    output flush, redir_valid, redir_pc, exc_intr,
           status, cause, epc, badvaddr
  );
endinterface

// File: rtl/exc_commit.sv
// Exception commit unit: accepts the winning exception from the priority
// encoder, flushes the pipeline, updates CP0 (Status/Cause/EPC/BadVAddr)
// and holds a redirect to the exception vector (or EPC for ERET) until the
// fetch stage acknowledges it.
// Optional feature: define EXC_TLBR_VEC_EN to send TLB refill exceptions
// taken with Status.EXL=0 to vector offset 0x000 instead of 0x180.
module exc_commit #(
  parameter int EXCT_W = 5
) (
  input  logic       clk,
  input  logic       resetn,
  exc_commit_if.slave bus
);

  // ExcType encoding shared with the priority encoder
  localparam logic [EXCT_W-1:0] EXC_INTR = EXCT_W'(1);
  localparam logic [EXCT_W-1:0] EXC_ADE  = EXCT_W'(2);
  localparam logic [EXCT_W-1:0] EXC_TLBR = EXCT_W'(3);
  localparam logic [EXCT_W-1:0] EXC_TLBI = EXCT_W'(4);
  localparam logic [EXCT_W-1:0] EXC_TLBM = EXCT_W'(5);
  localparam logic [EXCT_W-1:0] EXC_IBE  = EXCT_W'(6);
  localparam logic [EXCT_W-1:0] EXC_DBE  = EXCT_W'(7);
  localparam logic [EXCT_W-1:0] EXC_CPU  = EXCT_W'(8);
  localparam logic [EXCT_W-1:0] EXC_RI   = EXCT_W'(9);
  localparam logic [EXCT_W-1:0] EXC_OV   = EXCT_W'(10);
  localparam logic [EXCT_W-1:0] EXC_TRAP = EXCT_W'(11);
  localparam logic [EXCT_W-1:0] EXC_SYSC = EXCT_W'(12);
  localparam logic [EXCT_W-1:0] EXC_BP   = EXCT_W'(13);
  localparam logic [EXCT_W-1:0] EXC_ERET = EXCT_W'(14);

  localparam logic [31:0] STATUS_RST  = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMSK = 32'h0040_FF03; // BEV, IM, EXL, IE

  typedef enum logic {IDLE, REDIR} state_t;

  state_t      state_q, state_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        flush;
  logic [4:0]  exc_code;
  logic        addr_exc;
  logic [31:0] vec_base;
  logic [31:0] vec_off;

  // Cause.ExcCode and BadVAddr-capturing classes for the incoming exception
  always_comb begin
    exc_code = 5'd0;
    addr_exc = 1'b0;
    case (bus.exc_type)
      EXC_INTR: exc_code = 5'd0;
      EXC_TLBM: begin exc_code = 5'd1; addr_exc = 1'b1; end
      EXC_TLBR,
      EXC_TLBI: begin exc_code = bus.m_wr ? 5'd3 : 5'd2; addr_exc = 1'b1; end
      EXC_ADE:  begin exc_code = bus.m_wr ? 5'd5 : 5'd4; addr_exc = 1'b1; end
      EXC_IBE:  exc_code = 5'd6;
      EXC_DBE:  exc_code = 5'd7;
      EXC_SYSC: exc_code = 5'd8;
      EXC_BP:   exc_code = 5'd9;
      EXC_RI:   exc_code = 5'd10;
      EXC_CPU:  exc_code = 5'd11;
      EXC_OV:   exc_code = 5'd12;
      EXC_TRAP: exc_code = 5'd13;
      default:  exc_code = 5'd0;
    endcase
  end

  // Exception vector from Status.BEV and the exception class
  always_comb begin
    vec_base = status_q[22] ? 32'hBFC0_0200 : 32'h8000_0000;
`ifdef EXC_TLBR_VEC_EN
    vec_off  = (bus.exc_type == EXC_TLBR && !status_q[1]) ? 32'h0 : 32'h180;
`else
    vec_off  = 32'h180;
`endif
  end

  // Next state: MTC0 first, then the exception update overrides shared fields
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    redir_pc_d = redir_pc_q;
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    flush      = 1'b0;

    if (bus.cp0_we) begin
      case (bus.cp0_waddr)
        5'd12:   status_d = (status_q & ~STATUS_WMSK) | (bus.cp0_wdata & STATUS_WMSK);
        5'd13:   cause_d[9:8] = bus.cp0_wdata[9:8];
        5'd14:   epc_d = bus.cp0_wdata;
        default: ;
      endcase
    end

    cause_d[15:10] = bus.ext_int;

    case (state_q)
      IDLE: begin
        if (bus.exc_flag) begin
          flush   = 1'b1;
          state_d = REDIR;
          if (bus.exc_type == EXC_ERET) begin
            status_d[1] = 1'b0;
            redir_pc_d  = epc_q;
          end else begin
            if (!status_q[1]) begin
              epc_d       = bus.in_delay ? bus.pc - 32'd4 : bus.pc;
              cause_d[31] = bus.in_delay;
            end
            status_d[1]   = 1'b1;
            cause_d[6:2]  = exc_code;
            if (addr_exc) badvaddr_d = bus.exc_baddr;
            redir_pc_d    = vec_base + vec_off;
          end
        end
      end
      REDIR: begin
        if (bus.redir_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and CP0 registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      redir_pc_q <= 32'h0;
      status_q   <= STATUS_RST;
      cause_q    <= 32'h0;
      epc_q      <= 32'h0;
      badvaddr_q <= 32'h0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q    <= state_d;
      redir_pc_q <= redir_pc_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  assign bus.flush       = flush;
  assign bus.redir_valid = (state_q == REDIR);
  assign bus.redir_pc    = redir_pc_q;
  assign bus.exc_intr    = (|(cause_q[15:8] & status_q[15:8])) & status_q[0] & ~status_q[1];
  assign bus.status      = status_q;
  assign bus.cause       = cause_q;
  assign bus.epc         = epc_q;
  assign bus.badvaddr    = badvaddr_q;

endmodule

// File: tb/tb_exc_commit.sv
// Directed bench for exc_commit: redirect targets go through a scoreboard
// queue, CP0 register state is compared against hand-derived constants.
module tb_exc_commit;

  localparam logic [4:0] T_INTR = 5'd1,  T_ADE  = 5'd2,  T_TLBR = 5'd3;
  localparam logic [4:0] T_IBE  = 5'd6,  T_OV   = 5'd10, T_SYSC = 5'd12;
  localparam logic [4:0] T_ERET = 5'd14;

`ifdef EXC_TLBR_VEC_EN
  localparam logic [31:0] TLBR_VEC = 32'h8000_0000;
`else
  localparam logic [31:0] TLBR_VEC = 32'h8000_0180;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] sb[$];

  exc_commit_if #(.EXCT_W(5)) bus ();

  exc_commit #(.EXCT_W(5)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Pop the next expected redirect target and compare against the DUT
  task automatic sb_pop(input string tag, output logic [31:0] exp);
    if (sb.size() == 0) begin
      exp = 32'hx;
      checks++;
      errors++;
      $error("FAIL %s: observed redirect with empty scoreboard expected none", tag);
    end else begin
      exp = sb.pop_front();
      chk(tag, bus.redir_pc, exp);
    end
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    bus.cp0_we    = 1'b1;
    bus.cp0_waddr = addr;
    bus.cp0_wdata = data;
    @(negedge clk);
    bus.cp0_we    = 1'b0;
  endtask

  // Issue one exception at a negedge; hold the redirect for 'hold' cycles
  // (with a spurious exc_flag asserted) before acknowledging it.
  task automatic do_exc(input string tag, input logic [4:0] t, input logic [31:0] p,
                        input logic [31:0] ba, input logic d, input logic w,
                        input logic [31:0] exp_pc, input int hold);
    logic [31:0] cur;
    bus.exc_flag  = 1'b1;
    bus.exc_type  = t;
    bus.pc        = p;
    bus.exc_baddr = ba;
    bus.in_delay  = d;
    bus.m_wr      = w;
    sb.push_back(exp_pc);
    #1 chk({tag, "_flush"}, 32'(bus.flush), 32'd1);
    @(negedge clk);
    bus.exc_flag = 1'b0;
    #1 chk({tag, "_flush_drop"}, 32'(bus.flush), 32'd0);
    chk({tag, "_rvalid"}, 32'(bus.redir_valid), 32'd1);
    sb_pop({tag, "_redir_pc"}, cur);
    for (int i = 0; i < hold; i++) begin
      bus.exc_flag = 1'b1;
      bus.exc_type = T_OV;
      #1 chk({tag, "_flush_in_redir"}, 32'(bus.flush), 32'd0);
      @(negedge clk);
      chk({tag, "_rvalid_hold"}, 32'(bus.redir_valid), 32'd1);
      chk({tag, "_redir_pc_hold"}, bus.redir_pc, cur);
    end
    bus.exc_flag  = 1'b0;
    bus.redir_ack = 1'b1;
    @(negedge clk);
    bus.redir_ack = 1'b0;
    #1 chk({tag, "_rvalid_after_ack"}, 32'(bus.redir_valid), 32'd0);
  endtask

  initial begin
    bus.exc_flag  = 1'b0;
    bus.exc_type  = 5'd0;
    bus.exc_baddr = 32'h0;
    bus.pc        = 32'h0;
    bus.in_delay  = 1'b0;
    bus.m_wr      = 1'b0;
    bus.ext_int   = 6'd0;
    bus.cp0_we    = 1'b0;
    bus.cp0_waddr = 5'd0;
    bus.cp0_wdata = 32'h0;
    bus.redir_ack = 1'b0;

    // Reset and release
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_status", bus.status, 32'h0040_0000);
    chk("rst_cause", bus.cause, 32'h0);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_badvaddr", bus.badvaddr, 32'h0);
    chk("rst_rvalid", 32'(bus.redir_valid), 32'd0);
    chk("rst_redir_pc", bus.redir_pc, 32'h0);
    chk("rst_exc_intr", 32'(bus.exc_intr), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);

    // redir_ack in IDLE has no effect
    bus.redir_ack = 1'b1;
    @(negedge clk);
    bus.redir_ack = 1'b0;
    chk("idle_ack_rvalid", 32'(bus.redir_valid), 32'd0);

    // MTC0 write masks
    mtc0(5'd12, 32'hFFFF_FFFF);
    chk("mtc0_status_mask", bus.status, 32'h0040_FF03);
    mtc0(5'd8, 32'hFFFF_FFFF);
    chk("mtc0_badvaddr_ro", bus.badvaddr, 32'h0);
    mtc0(5'd12, 32'h0);
    chk("mtc0_status_clr", bus.status, 32'h0);

    // SysC, redirect held 3 cycles with exc_flag ignored
    do_exc("sysc", T_SYSC, 32'h8000_1000, 32'h0000_DEAD, 1'b0, 1'b0, 32'h8000_0180, 3);
    chk("sysc_epc", bus.epc, 32'h8000_1000);
    chk("sysc_cause", bus.cause, 32'h0000_0020);
    chk("sysc_status", bus.status, 32'h0000_0002);
    chk("sysc_badvaddr", bus.badvaddr, 32'h0);

    // ERET returns to EPC and clears EXL
    do_exc("eret1", T_ERET, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8000_1000, 0);
    chk("eret1_status", bus.status, 32'h0);
    chk("eret1_cause", bus.cause, 32'h0000_0020);

    // Store AdE in a delay slot
    do_exc("ade", T_ADE, 32'h8000_2004, 32'h0000_0003, 1'b1, 1'b1, 32'h8000_0180, 0);
    chk("ade_epc", bus.epc, 32'h8000_2000);
    chk("ade_cause", bus.cause, 32'h8000_0014);
    chk("ade_badvaddr", bus.badvaddr, 32'h0000_0003);
    do_exc("eret2", T_ERET, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8000_2000, 0);

    // TLBR load with EXL=0, then again with EXL=1
    do_exc("tlbr0", T_TLBR, 32'h8000_4000, 32'h0040_0000, 1'b0, 1'b0, TLBR_VEC, 0);
    chk("tlbr0_epc", bus.epc, 32'h8000_4000);
    chk("tlbr0_cause", bus.cause, 32'h0000_0008);
    chk("tlbr0_badvaddr", bus.badvaddr, 32'h0040_0000);
    do_exc("tlbr1", T_TLBR, 32'h8000_5000, 32'h0050_0000, 1'b1, 1'b0, 32'h8000_0180, 0);
    chk("tlbr1_epc", bus.epc, 32'h8000_4000);
    chk("tlbr1_cause", bus.cause, 32'h0000_0008);
    chk("tlbr1_badvaddr", bus.badvaddr, 32'h0050_0000);

    // ERET to a software-written EPC
    mtc0(5'd14, 32'h8000_3000);
    do_exc("eret3", T_ERET, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8000_3000, 0);
    chk("eret3_status", bus.status, 32'h0);
    chk("eret3_epc", bus.epc, 32'h8000_3000);

    // Interrupt pending path
    mtc0(5'd12, 32'h0000_0401);
    bus.ext_int = 6'd1;
    #1 chk("intr_not_yet", 32'(bus.exc_intr), 32'd0);
    @(negedge clk);
    chk("intr_pending", 32'(bus.exc_intr), 32'd1);
    chk("intr_cause_ip", bus.cause, 32'h0000_0408);
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk("mtc0_cause_mask", bus.cause, 32'h0000_0708);

    // Same-edge MTC0 EPC and Ov exception: exception wins EPC
    bus.exc_flag  = 1'b1;
    bus.exc_type  = T_OV;
    bus.pc        = 32'h8000_6000;
    bus.in_delay  = 1'b0;
    bus.cp0_we    = 1'b1;
    bus.cp0_waddr = 5'd14;
    bus.cp0_wdata = 32'h1234_5678;
    sb.push_back(32'h8000_0180);
    #1 chk("ov_flush", 32'(bus.flush), 32'd1);
    @(negedge clk);
    bus.exc_flag = 1'b0;
    bus.cp0_we   = 1'b0;
    #1 chk("ov_rvalid", 32'(bus.redir_valid), 32'd1);
    begin
      logic [31:0] dummy;
      sb_pop("ov_redir_pc", dummy);
    end
    chk("ov_epc", bus.epc, 32'h8000_6000);
    chk("ov_cause", bus.cause, 32'h0000_0730);
    chk("ov_intr_masked", 32'(bus.exc_intr), 32'd0);

    // Reset while the redirect is pending
    resetn = 1'b0;
    #1 chk("rst_redir_rvalid", 32'(bus.redir_valid), 32'd0);
    chk("rst_redir_status", bus.status, 32'h0040_0000);
    chk("rst_redir_pc", bus.redir_pc, 32'h0);
    bus.ext_int = 6'd0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_rvalid", 32'(bus.redir_valid), 32'd0);
    end

    // BEV=1 vector base
    do_exc("ibe", T_IBE, 32'h8000_7000, 32'h0000_1234, 1'b0, 1'b0, 32'hBFC0_0380, 0);
    chk("ibe_cause", bus.cause, 32'h0000_0018);
    chk("ibe_epc", bus.epc, 32'h8000_7000);
    chk("ibe_badvaddr", bus.badvaddr, 32'h0);
    chk("ibe_status", bus.status, 32'h0040_0002);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_commit.md
EXC_COMMIT -- requirements
Module: exc_commit

Interface
REQ-001 SHALL have parameter EXCT_W, default 5: width of exc_type, using the codebase ExcType encoding.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- exc_flag  in  1  exception request from the priority encoder.
- exc_type  in  EXCT_W  winning exception class (NoExc, Intr, AdE, TLBR, TLBI, TLBM, IBE, DBE, CpU, RI, Ov, Trap, SysC, Bp, ERET).
- exc_baddr  in  32  faulting address.
- pc  in  32  PC of the excepting instruction.
- in_delay  in  1  instruction is in a branch delay slot.
- m_wr  in  1  faulting memory access is a store.
- ext_int  in  6  hardware interrupt lines.
- cp0_we  in  1  MTC0 write strobe.
- cp0_waddr  in  5  register number: 8 BadVAddr, 12 Status, 13 Cause, 14 EPC.
- cp0_wdata  in  32  MTC0 data.
- redir_ack  in  1  fetch stage accepts the redirect.
- flush  out  1  pipeline flush pulse.
- redir_valid  out  1  redirect target valid.
- redir_pc  out  32  redirect target.
- exc_intr  out  1  interrupt pending, fed back to the encoder.
- status, cause, epc, badvaddr  out  32 each  architectural CP0 registers.

Function
REQ-003 SHALL implement a two-state FSM: IDLE and REDIR.
REQ-004 In IDLE with exc_flag=1, SHALL in the same cycle assert flush=1 for exactly one cycle, update CP0 on the next edge, and go to REDIR.
REQ-005 In REDIR, SHALL hold redir_valid=1 with redir_pc stable until the cycle redir_ack=1; the FSM SHALL return to IDLE on that edge.
REQ-006 In REDIR, SHALL ignore exc_flag; redir_ack in IDLE SHALL have no effect.
REQ-007 For non-ERET exceptions with Status.EXL=0 at entry, SHALL write:
- EPC = in_delay ? pc-4 : pc.
- Cause.BD (bit 31) = in_delay.
- Status.EXL (bit 1) = 1.
REQ-008 If Status.EXL=1 at entry, SHALL leave EPC and Cause.BD unchanged and still write Cause.ExcCode.
REQ-009 Cause.ExcCode (bits 6:2) SHALL map as follows:
- Intr 0, TLBM 1.
- TLBR/TLBI: 2 load, 3 store (per m_wr).
- AdE: 4 load, 5 store (per m_wr).
- IBE 6, DBE 7, SysC 8, Bp 9, RI 10, CpU 11, Ov 12, Trap 13.
REQ-010 For AdE, TLBR, TLBI and TLBM, SHALL set BadVAddr = exc_baddr; BadVAddr SHALL otherwise be unchanged.
REQ-011 Vector base SHALL be 0xBFC00200 when Status.BEV (bit 22) = 1, else 0x80000000; offset SHALL be 0x180, except as in REQ-021.
REQ-012 For ERET, SHALL clear Status.EXL, leave ExcCode/EPC unchanged, and set redir_pc = EPC as sampled in the acceptance cycle.
REQ-013 Cause.IP[7:2] (bits 15:10) SHALL be registered from ext_int every cycle.
REQ-014 Cause.IP[1:0] SHALL be writable only via MTC0 to Cause.
REQ-015 exc_intr SHALL equal |(Cause.IP & Status.IM[15:8]) & Status.IE (bit 0) & ~Status.EXL, combinational from registers.
REQ-016 MTC0 writable fields:
- Status: bits 22, 15:8, 1, 0.
- Cause: bits 9:8.
- EPC: all bits.
- BadVAddr: not writable.
- Other bits read as 0.
REQ-017 When an MTC0 write and an exception update land on the same edge, the exception update SHALL win for every overlapping field; non-overlapping written fields SHALL still take effect.

Reset
REQ-018 On resetn=0, SHALL asynchronously set:
- FSM to IDLE; flush=0, redir_valid=0, redir_pc=0.
- status=0x00400000; cause=0, epc=0, badvaddr=0.
REQ-019 Reset mid-REDIR SHALL drop the pending redirect; no redirect SHALL appear after deassertion.
REQ-020 After deassertion, the first update SHALL occur at the first rising edge with resetn=1.

Configuration
REQ-021 Macro EXC_TLBR_VEC_EN:
- Defined: TLBR with Status.EXL=0 SHALL use offset 0x000.
- Undefined: all exceptions SHALL use offset 0x180.

Verification
REQ-022 Reset then release with ext_int=0 -> status=0x00400000, cause=0, redir_valid=0, exc_intr=0.
REQ-023 SysC, pc=0x80001000, in_delay=0, BEV=0; redir_ack held 0 for 3 cycles -> flush 1 cycle, epc=0x80001000, ExcCode=8, EXL=1, redir_pc=0x80000180 stable until ack, then IDLE.
REQ-024 Store AdE in delay slot, pc=0x80002004, exc_baddr=0x00000003 -> epc=0x80002000, BD=1, ExcCode=5, badvaddr=0x00000003.
REQ-025 TLBR load, EXL=0, BEV=0 -> redir_pc=0x80000000 with EXC_TLBR_VEC_EN, 0x80000180 without; repeat with EXL=1 -> 0x80000180 and epc unchanged.
REQ-026 Status=0x00000401 with ext_int[0]=1 -> exc_intr=1 one cycle later; an ERET with EPC=0x80003000 -> EXL=0, redir_pc=0x80003000.
REQ-027 Same-edge MTC0 EPC=0x12345678 and Ov exception -> epc=pc; resetn pulled low in REDIR -> redir_valid=0 immediately, no redirect after release.
